// File: rtl/gmii_tx_framer.sv
// ---------------------------------------------------------------------------
// gmii_tx_framer
//
// Ethernet MAC transmit framer. Raw frame bytes (destination MAC through
// payload) arrive on a GMII-style in_txd/in_txdv pair, pass through a
// one-byte skid register into a small FIFO, and leave as a complete 802.3
// frame: 7 x 0x55 preamble, 0xD5 SFD, the buffered data, zero padding up to
// MIN_FRAME bytes, the FCS, then IFG idle cycles before the next frame.
//
// Optional feature macro: GMII_TX_FCS_EN
//   defined     -> CRC-32 logic present, 4 FCS bytes appended.
//   not defined -> no CRC logic, the frame ends after the data/pad bytes.
//
// Parameters:
//   FIFO_AW    FIFO address width, depth = 2**FIFO_AW entries of {last, data}
//   MIN_FRAME  minimum data+pad bytes before the FCS (0 disables padding)
//   IFG        idle cycles with gmii_txen low after a frame (must be >= 1)
//
// Ports:
//   clk_125m   in   GMII transmit clock
//   rst_n      in   asynchronous, active-low reset
//   in_txd     in   [7:0] payload byte, valid when in_txdv = 1
//   in_txdv    in   high for each valid byte; a contiguous run is one frame
//   gmii_txd   out  [7:0] framed byte to the RGMII TX stage
//   gmii_txen  out  transmit enable
//   gmii_txer  out  transmit error (underrun abort byte)
//   busy       out  framer not idle or FIFO holding data
//   ovf_err    out  sticky FIFO overflow flag, cleared only by reset
//   unf_err    out  sticky FIFO underrun flag, cleared only by reset
// ---------------------------------------------------------------------------
module gmii_tx_framer #(
  parameter int FIFO_AW   = 5,
  parameter int MIN_FRAME = 60,
  parameter int IFG       = 12
) (
  input  logic       clk_125m,
  input  logic       rst_n,
  input  logic [7:0] in_txd,
  input  logic       in_txdv,
  output logic [7:0] gmii_txd,
  output logic       gmii_txen,
  output logic       gmii_txer,
  output logic       busy,
  output logic       ovf_err,
  output logic       unf_err
);

  localparam int          DEPTH    = 1 << FIFO_AW;
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam int          GAP_W    = (IFG > 1) ? $clog2(IFG) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IFG - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    PAD,
    FCS,
    GAP
  } state_t;

  state_t state;

  // -------------------------------------------------------------------------
  // Input skid register
  // -------------------------------------------------------------------------
  logic [7:0] skid_data;
  logic       skid_valid;

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      skid_data  <= 8'h00;
      skid_valid <= 1'b0;
    end else begin
      skid_valid <= in_txdv;
      if (in_txdv) begin
        skid_data <= in_txd;
      end
    end
  end

  // The held byte always leaves the skid register one cycle later: either
  // the next byte pushes it out (last=0) or in_txdv has dropped (last=1).
  logic       wr_req;
  logic [8:0] wr_entry;

  always_comb begin
    wr_req   = skid_valid;
    wr_entry = {~in_txdv, skid_data};
  end

  // -------------------------------------------------------------------------
  // FIFO
  // -------------------------------------------------------------------------
  logic [8:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop;
  logic             wr_accept;
  logic [8:0]       fifo_head;
  logic             cur_last;

  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                 (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    fifo_head  = mem[rd_ptr[FIFO_AW-1:0]];
  end

  // A pop happens whenever the framer needs the next data byte: on leaving
  // SFD, and in DATA until the entry marked last has been sent.
  always_comb begin
    pop = 1'b0;
    case (state)
      SFD:     pop = !fifo_empty;
      DATA:    pop = !cur_last && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  // On a full FIFO a simultaneous read frees the slot being written.
  always_comb begin
    wr_accept = wr_req && (!fifo_full || pop);
  end

  always_ff @(posedge clk_125m) begin
    if (wr_accept) begin
      mem[wr_ptr[FIFO_AW-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      ovf_err <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (wr_req && !wr_accept) begin
        ovf_err <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // CRC-32 (reflected form of 0x04C11DB7)
  // -------------------------------------------------------------------------
`ifdef GMII_TX_FCS_EN
  logic [31:0] crc;
  logic [1:0]  fcs_cnt;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  din);
    logic [31:0] c;
    c = crc_in ^ {24'h000000, din};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction
`endif

  // -------------------------------------------------------------------------
  // Framing FSM
  // -------------------------------------------------------------------------
  logic [2:0]       pre_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [10:0]      byte_cnt;
  logic [10:0]      cnt_inc;

  always_comb begin
    cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  end

  // Outputs are loaded on the edge that enters a state, so each state's
  // registers describe the byte currently on the wire.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre_cnt   <= 3'd0;
      gap_cnt   <= '0;
      byte_cnt  <= 11'd0;
      cur_last  <= 1'b0;
      rd_ptr    <= '0;
      gmii_txd  <= 8'h00;
      gmii_txen <= 1'b0;
      gmii_txer <= 1'b0;
      unf_err   <= 1'b0;
`ifdef GMII_TX_FCS_EN
      crc       <= 32'hFFFFFFFF;
      fcs_cnt   <= 2'd0;
`endif
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      case (state)
        IDLE: begin
          gmii_txd  <= 8'h00;
          gmii_txen <= 1'b0;
          gmii_txer <= 1'b0;
          byte_cnt  <= 11'd0;
          if (!fifo_empty) begin
            state     <= PRE;
            gmii_txen <= 1'b1;
            gmii_txd  <= 8'h55;
            pre_cnt   <= 3'd0;
          end
        end

        PRE: begin
          cur_last <= 1'b0;
          if (pre_cnt == 3'd6) begin
            state    <= SFD;
            gmii_txd <= 8'hD5;
`ifdef GMII_TX_FCS_EN
            crc      <= 32'hFFFFFFFF;
`endif
          end else begin
            pre_cnt <= pre_cnt + 3'd1;
          end
        end

        // SFD, DATA and PAD all choose the next body byte: more data, a pad
        // byte, the end of the body, or an abort when data has run dry.
        SFD, DATA, PAD: begin
          if ((state == PAD) || (state == DATA && cur_last)) begin
            if (byte_cnt < MIN_CNT) begin
              state    <= PAD;
              gmii_txd <= 8'h00;
              byte_cnt <= cnt_inc;
`ifdef GMII_TX_FCS_EN
              crc      <= crc32_byte(crc, 8'h00);
`endif
            end else begin
`ifdef GMII_TX_FCS_EN
              state    <= FCS;
              gmii_txd <= ~crc[7:0];
              crc      <= {8'h00, crc[31:8]};
              fcs_cnt  <= 2'd0;
`else
              state     <= GAP;
              gmii_txen <= 1'b0;
              gmii_txd  <= 8'h00;
              gap_cnt   <= '0;
`endif
            end
          end else if (fifo_empty) begin
            // Underrun: one abort byte with txer, then straight to the gap.
            state     <= GAP;
            gmii_txd  <= 8'h00;
            gmii_txer <= 1'b1;
            unf_err   <= 1'b1;
            gap_cnt   <= '0;
          end else begin
            state    <= DATA;
            gmii_txd <= fifo_head[7:0];
            cur_last <= fifo_head[8];
            byte_cnt <= cnt_inc;
`ifdef GMII_TX_FCS_EN
            crc      <= crc32_byte(crc, fifo_head[7:0]);
`endif
          end
        end

`ifdef GMII_TX_FCS_EN
        FCS: begin
          if (fcs_cnt == 2'd3) begin
            state     <= GAP;
            gmii_txen <= 1'b0;
            gmii_txd  <= 8'h00;
            gap_cnt   <= '0;
          end else begin
            gmii_txd <= ~crc[7:0];
            crc      <= {8'h00, crc[31:8]};
            fcs_cnt  <= fcs_cnt + 2'd1;
          end
        end
`endif

        // The gap counts only cycles with txen low; the first GAP cycle after
        // an underrun still carries the abort byte. A waiting frame starts
        // its preamble directly so the gap is exactly IFG cycles.
        GAP: begin
          gmii_txen <= 1'b0;
          gmii_txer <= 1'b0;
          gmii_txd  <= 8'h00;
          if (gmii_txen) begin
            gap_cnt <= '0;
          end else if (gap_cnt == GAP_LAST) begin
            byte_cnt <= 11'd0;
            if (!fifo_empty) begin
              state     <= PRE;
              gmii_txen <= 1'b1;
              gmii_txd  <= 8'h55;
              pre_cnt   <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          gmii_txen <= 1'b0;
          gmii_txer <= 1'b0;
          gmii_txd  <= 8'h00;
        end
      endcase
    end
  end

  // Includes the skid register so a frame just arriving already shows busy.
  always_ff @(posedge clk_125m or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (state != IDLE) || !fifo_empty || skid_valid;
    end
  end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_gmii_tx_framer
//
// Directed bench for gmii_tx_framer. Three instances share clock and reset:
//   dut_a  default parameters
//   dut_b  MIN_FRAME = 0 (no padding)
//   dut_c  FIFO_AW = 3 (small FIFO, used to force an overflow)
// Expected frames are built by the bench from the stimulus bytes (preamble,
// SFD, padding and a bit-serial CRC-32 reference), plus hand-computed
// constants for the "123456789" check value.
// ---------------------------------------------------------------------------
module tb_gmii_tx_framer;

`ifdef GMII_TX_FCS_EN
  localparam int FCS_BYTES = 4;
`else
  localparam int FCS_BYTES = 0;
`endif

  logic       clk_125m = 1'b0;
  logic       rst_n    = 1'b0;
  logic [7:0] in_txd   = 8'h00;
  logic       dv_a = 1'b0, dv_b = 1'b0, dv_c = 1'b0;

  logic [7:0] txd_a, txd_b, txd_c;
  logic       txen_a, txen_b, txen_c;
  logic       txer_a, txer_b, txer_c;
  logic       busy_a, busy_b, busy_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic       unf_a, unf_b, unf_c;

  always #4 clk_125m = ~clk_125m;

  gmii_tx_framer dut_a (
    .clk_125m (clk_125m), .rst_n (rst_n),
    .in_txd   (in_txd),   .in_txdv (dv_a),
    .gmii_txd (txd_a),    .gmii_txen (txen_a), .gmii_txer (txer_a),
    .busy     (busy_a),   .ovf_err (ovf_a),    .unf_err (unf_a)
  );

  gmii_tx_framer #(.MIN_FRAME(0)) dut_b (
    .clk_125m (clk_125m), .rst_n (rst_n),
    .in_txd   (in_txd),   .in_txdv (dv_b),
    .gmii_txd (txd_b),    .gmii_txen (txen_b), .gmii_txer (txer_b),
    .busy     (busy_b),   .ovf_err (ovf_b),    .unf_err (unf_b)
  );

  gmii_tx_framer #(.FIFO_AW(3)) dut_c (
    .clk_125m (clk_125m), .rst_n (rst_n),
    .in_txd   (in_txd),   .in_txdv (dv_c),
    .gmii_txd (txd_c),    .gmii_txen (txen_c), .gmii_txer (txer_c),
    .busy     (busy_c),   .ovf_err (ovf_c),    .unf_err (unf_c)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk_125m) cyc <= cyc + 1;

  // Monitor on the selected instance, sampled on the falling edge.
  int         mon_sel = 0;
  logic [7:0] m_txd;
  logic       m_txen;
  logic       m_txer;
  logic       prev_txen = 1'b0;
  logic [7:0] cap_q[$];
  int         rise_q[$];
  int         fall_q[$];
  int         txer_seen = 0;

  always_comb begin
    case (mon_sel)
      0:       begin m_txd = txd_a; m_txen = txen_a; m_txer = txer_a; end
      1:       begin m_txd = txd_b; m_txen = txen_b; m_txer = txer_b; end
      default: begin m_txd = txd_c; m_txen = txen_c; m_txer = txer_c; end
    endcase
  end

  always @(negedge clk_125m) begin
    if (m_txen) begin
      if (!prev_txen) rise_q.push_back(cyc);
      cap_q.push_back(m_txd);
    end else if (prev_txen) begin
      fall_q.push_back(cyc);
    end
    if (m_txer) txer_seen++;
    prev_txen = m_txen;
  end

  logic [7:0] tx_data[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] expected);
    checks++;
    if (got !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    end
  endtask

  task automatic setValid(input int sel, input logic v);
    case (sel)
      0:       dv_a = v;
      1:       dv_b = v;
      default: dv_c = v;
    endcase
  endtask

  task automatic clearMonitor();
    @(negedge clk_125m);
    #1;
    cap_q.delete();
    rise_q.delete();
    fall_q.delete();
    txer_seen = 0;
  endtask

  // Drives tx_data as one frame on instance sel. When abort_at >= 0 the
  // reset is asserted while that byte would be driven.
  task automatic applyStimulus(input int sel, input int abort_at);
    for (int i = 0; i < tx_data.size(); i++) begin
      @(negedge clk_125m);
      if (i == 0) start_cyc = cyc;
      if (i == abort_at) begin
        checkOutput("abort_txen_before", {31'd0, m_txen}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_txen", {31'd0, m_txen}, 32'd0);
        checkOutput("abort_txd", {24'd0, m_txd}, 32'd0);
        setValid(sel, 1'b0);
        in_txd = 8'h00;
        return;
      end
      in_txd = tx_data[i];
      setValid(sel, 1'b1);
    end
    @(negedge clk_125m);
    setValid(sel, 1'b0);
    in_txd = 8'h00;
  endtask

  task automatic waitFrames(input int n, input int budget);
    int k = 0;
    while (fall_q.size() < n && k < budget) begin
      @(negedge clk_125m);
      #1;
      k++;
    end
    checkOutput("frames_done", fall_q.size(), n);
  endtask

  // Reference frame: preamble, SFD, body padded to min_len, CRC-32 LSB first.
  task automatic buildExpected(input int min_len);
    logic [7:0]  body[$];
    logic [31:0] c;
    logic        fb;
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    body = tx_data;
    while (body.size() < min_len) body.push_back(8'h00);
    foreach (body[i]) exp_q.push_back(body[i]);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ body[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    c = ~c;
    for (int i = 0; i < FCS_BYTES; i++) exp_q.push_back(c[8*i +: 8]);
  endtask

  task automatic checkFrame(input string tag, input int fidx);
    int base = 0;
    int len;
    logic [7:0] got;
    if (fall_q.size() <= fidx || rise_q.size() <= fidx) begin
      checkOutput({tag, "_present"}, fall_q.size(), fidx + 1);
      return;
    end
    for (int f = 0; f < fidx; f++) base += fall_q[f] - rise_q[f];
    len = fall_q[fidx] - rise_q[fidx];
    checkOutput({tag, "_len"}, len, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx;
      checkOutput($sformatf("%s_b%0d", tag, i), {24'd0, got}, {24'd0, exp_q[i]});
    end
  endtask

  function automatic int firstRise();
    return (rise_q.size() > 0) ? rise_q[0] : -1000;
  endfunction

  initial begin
    // Reset values
    repeat (3) @(negedge clk_125m);
    checkOutput("rst_txd",  {24'd0, txd_a}, 32'd0);
    checkOutput("rst_txen", {31'd0, txen_a}, 32'd0);
    checkOutput("rst_txer", {31'd0, txer_a}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_ovf",  {31'd0, ovf_a}, 32'd0);
    checkOutput("rst_unf",  {31'd0, unf_a}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_125m);

    // "123456789" check value, no padding
    mon_sel = 1;
    clearMonitor();
    tx_data = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    buildExpected(0);
    applyStimulus(1, -1);
    waitFrames(1, 200);
    checkOutput("crc9_latency", firstRise() - start_cyc, 32'd3);
    checkOutput("crc9_txen_cycles", (fall_q.size() > 0) ? fall_q[0] - firstRise() : -1,
                17 + FCS_BYTES);
    checkFrame("crc9", 0);
`ifdef GMII_TX_FCS_EN
    if (cap_q.size() >= 21) begin
      checkOutput("crc9_fcs0", {24'd0, cap_q[17]}, 32'h26);
      checkOutput("crc9_fcs1", {24'd0, cap_q[18]}, 32'h39);
      checkOutput("crc9_fcs2", {24'd0, cap_q[19]}, 32'hF4);
      checkOutput("crc9_fcs3", {24'd0, cap_q[20]}, 32'hCB);
    end else begin
      checkOutput("crc9_capture", cap_q.size(), 32'd21);
    end
`endif
    checkOutput("crc9_txer", txer_seen, 32'd0);
    repeat (20) @(negedge clk_125m);

    // Single-byte frame
    clearMonitor();
    tx_data = {8'hA5};
    buildExpected(0);
    applyStimulus(1, -1);
    waitFrames(1, 200);
    checkOutput("one_txen_cycles", (fall_q.size() > 0) ? fall_q[0] - firstRise() : -1,
                9 + FCS_BYTES);
    checkFrame("one", 0);
    repeat (20) @(negedge clk_125m);

    // Padding of a 20-byte frame
    mon_sel = 0;
    clearMonitor();
    tx_data.delete();
    for (int i = 0; i < 20; i++) tx_data.push_back(8'(i * 7 + 3));
    buildExpected(60);
    applyStimulus(0, -1);
    waitFrames(1, 300);
    checkOutput("pad_txen_cycles", (fall_q.size() > 0) ? fall_q[0] - firstRise() : -1,
                68 + FCS_BYTES);
    checkFrame("pad", 0);
    repeat (20) @(negedge clk_125m);

    // Back-to-back 64-byte frames
    clearMonitor();
    tx_data.delete();
    for (int i = 0; i < 64; i++) tx_data.push_back(8'(i));
    buildExpected(60);
    exp1_q = exp_q;
    applyStimulus(0, -1);
    tx_data.delete();
    for (int i = 0; i < 64; i++) tx_data.push_back(8'(255 - 3 * i));
    applyStimulus(0, -1);
    waitFrames(2, 500);
    checkOutput("b2b_gap", (rise_q.size() > 1 && fall_q.size() > 0) ?
                rise_q[1] - fall_q[0] : -1, 32'd12);
    exp_q = exp1_q;
    checkFrame("b2b1", 0);
    buildExpected(60);
    checkFrame("b2b2", 1);
    checkOutput("b2b_ovf", {31'd0, ovf_a}, 32'd0);
    checkOutput("b2b_unf", {31'd0, unf_a}, 32'd0);
`ifndef GMII_TX_FCS_EN
    checkOutput("nofcs_last_byte", (cap_q.size() > 0) ? {24'd0, cap_q[cap_q.size()-1]} : 32'hFFFF,
                {24'd0, tx_data[63]});
`endif
    repeat (20) @(negedge clk_125m);

    // Overflow on the small FIFO
    mon_sel = 2;
    clearMonitor();
    tx_data.delete();
    for (int i = 0; i < 100; i++) tx_data.push_back(8'(i + 1));
    applyStimulus(2, -1);
    waitFrames(1, 400);
    checkOutput("ovf_set", {31'd0, ovf_c}, 32'd1);
    repeat (30) @(negedge clk_125m);
    checkOutput("ovf_sticky", {31'd0, ovf_c}, 32'd1);
    checkOutput("ovf_other_inst", {31'd0, ovf_a}, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_125m);
    checkOutput("ovf_cleared", {31'd0, ovf_c}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_125m);

    // Reset during DATA, then a clean frame
    mon_sel = 0;
    clearMonitor();
    tx_data.delete();
    for (int i = 0; i < 64; i++) tx_data.push_back(8'(i ^ 8'h5A));
    applyStimulus(0, 30);
    repeat (2) @(negedge clk_125m);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_125m);
    checkOutput("rstmid_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rstmid_txen", {31'd0, txen_a}, 32'd0);
    clearMonitor();
    tx_data = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    buildExpected(60);
    applyStimulus(0, -1);
    waitFrames(1, 300);
    checkOutput("rstmid_latency", firstRise() - start_cyc, 32'd3);
    checkFrame("rstmid", 0);
    checkOutput("rstmid_unf", {31'd0, unf_a}, 32'd0);
    repeat (20) @(negedge clk_125m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
